// File: rtl/uart_pkg.sv
// Purpose: shared UART definitions (FSM encoding, counter sizing, parity modes).
// Latency: n/a (package only).
// Backpressure: n/a (package only).
//
// Contents:
//   ST_*           receiver FSM state encoding
//   PARITY_*       parity-mode encoding, shared with the matching transmitter
//   cnt_width()    width of a counter that must reach clks-1
package uart_pkg;

  // Receiver FSM states. Kept as plain 3-bit constants so older tools that
  // compare against raw state codes keep working.
  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_PARITY = 3'd3;
  localparam logic [2:0] ST_STOP   = 3'd4;

  // Parity-mode select: the value of the parity_odd input.
  localparam logic PARITY_EVEN = 1'b0;
  localparam logic PARITY_ODD  = 1'b1;

  // Width of a per-bit clock counter that counts 0 .. clks-1.
  // Guarded so a degenerate clks of 1 still yields a 1-bit counter.
  function automatic int unsigned cnt_width(input int unsigned clks);
    if (clks <= 1) begin
      return 1;
    end
    return $clog2(clks);
  endfunction

endpackage

// File: rtl/uart_sync.sv
// Purpose: STAGES-deep flop chain bringing an asynchronous level into the clock domain.
// Latency: STAGES cycles from d_i to q_o.
// Backpressure: none; samples every cycle.
//
// Ports:
//   clk_i  system clock
//   rst_i  synchronous active-high reset; every stage resets to 1 (idle line level)
//   d_i    asynchronous input
//   q_o    synchronised output
module uart_sync #(
  parameter int STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] sync_q;

  // Reset to 1 so an idle serial line or an idle GPIO pull-up never shows a
  // spurious falling edge as reset is released.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q <= '1;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
    end
  end

  assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/uart_rx_cfg.sv
// Purpose: runtime-configurable UART receiver (DATA_W data bits, optional even/odd parity, 1 or 2 stop bits).
// Latency: rx_valid rises about (1+DATA_W+parity+stops)*CLKS_PER_BIT - CLKS_PER_BIT/2 + 1 cycles after the synchronised start edge.
// Backpressure: one-entry holding register; a frame completing while it is full and not draining is dropped and sets sticky overrun.
//
// Ports:
//   PCLK, PRESET           clock and synchronous active-high reset
//   rx_en                  receiver enable; low aborts a frame in progress
//   parity_en/parity_odd   parity configuration, captured at the start edge
//   two_stop               check a second stop bit, captured at the start edge
//   rx_serial              asynchronous serial line, idle high
//   rx_data/rx_valid/rx_ready  holding register and its valid/ready handshake
//   parity_err/frame_err   error flags belonging to the held word
//   overrun                sticky dropped-frame flag, cleared by a handshake
//   busy                   FSM not idle
//
// Legal parameter ranges: CLKS_PER_BIT >= 4, DATA_W 5..9, SYNC_STAGES >= 2.
module uart_rx_cfg
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter int DATA_W       = 8,
  parameter int SYNC_STAGES  = 2
) (
  input  logic              PCLK,
  input  logic              PRESET,
  input  logic              rx_en,
  input  logic              parity_en,
  input  logic              parity_odd,
  input  logic              two_stop,
  input  logic              rx_serial,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  input  logic              rx_ready,
  output logic              parity_err,
  output logic              frame_err,
  output logic              overrun,
  output logic              busy
);

  localparam int CNT_W = cnt_width(CLKS_PER_BIT);
  localparam int IDX_W = $clog2(DATA_W);

  // Mid-bit point of the start bit and the full-period sample point.
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'((CLKS_PER_BIT - 1) / 2);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_W - 1);

  // ---------------------------------------------------------------------
  // Input synchroniser plus one extra copy for falling-edge detection
  // ---------------------------------------------------------------------
  logic rx_s;
  logic rx_q;

  uart_sync #(
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk_i (PCLK),
    .rst_i (PRESET),
    .d_i   (rx_serial),
    .q_o   (rx_s)
  );

  // ---------------------------------------------------------------------
  // Frame FSM state
  // ---------------------------------------------------------------------
  logic [2:0]        state_q,   state_d;
  logic [CNT_W-1:0]  cnt_q,     cnt_d;
  logic [IDX_W-1:0]  idx_q,     idx_d;
  logic [DATA_W-1:0] shift_q,   shift_d;
  logic              stop2_q,   stop2_d;     // in the second stop bit
  logic              pe_loc_q,  pe_loc_d;    // parity error of the frame in flight
  logic              fe_loc_q,  fe_loc_d;    // framing error of the frame in flight

  // Per-frame configuration snapshot taken at the start edge, so register
  // writes during a frame only apply to the next one.
  logic              cfg_par_q, cfg_par_d;
  logic              cfg_odd_q, cfg_odd_d;
  logic              cfg_two_q, cfg_two_d;

  // ---------------------------------------------------------------------
  // Holding register
  // ---------------------------------------------------------------------
  logic [DATA_W-1:0] rx_data_q,  rx_data_d;
  logic              rx_valid_q, rx_valid_d;
  logic              perr_q,     perr_d;
  logic              ferr_q,     ferr_d;
  logic              ovr_q,      ovr_d;

  logic              frame_done;   // final stop bit sampled this cycle
  logic              frame_fe;     // framing error including this cycle's sample
  logic              handshake;
  logic              load;
  logic              drop;

  // ---------------------------------------------------------------------
  // Next-state logic for the frame FSM
  // ---------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    shift_d    = shift_q;
    stop2_d    = stop2_q;
    pe_loc_d   = pe_loc_q;
    fe_loc_d   = fe_loc_q;
    cfg_par_d  = cfg_par_q;
    cfg_odd_d  = cfg_odd_q;
    cfg_two_d  = cfg_two_q;
    frame_done = 1'b0;
    frame_fe   = fe_loc_q | ~rx_s;

    case (state_q)
      ST_IDLE: begin
        // Only a genuine 1->0 transition starts a frame; a line stuck low
        // (break or framing error) cannot retrigger.
        if (rx_en && rx_q && !rx_s) begin
          state_d   = ST_START;
          cnt_d     = '0;
          idx_d     = '0;
          stop2_d   = 1'b0;
          pe_loc_d  = 1'b0;
          fe_loc_d  = 1'b0;
          cfg_par_d = parity_en;
          cfg_odd_d = parity_odd;
          cfg_two_d = two_stop;
        end
      end

      ST_START: begin
        if (cnt_q == CNT_HALF) begin
          // Re-check the line at mid start bit; a high line means the edge
          // was a glitch and the frame is silently abandoned.
          cnt_d   = '0;
          state_d = rx_s ? ST_IDLE : ST_DATA;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      ST_DATA: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d          = '0;
          shift_d[idx_q] = rx_s;
          if (idx_q == IDX_LAST) begin
            state_d = cfg_par_q ? ST_PARITY : ST_STOP;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      ST_PARITY: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d    = '0;
          // Data XOR parity bit is 0 for correct even parity, 1 for correct
          // odd parity; folding in the mode leaves 1 only on a mismatch.
          pe_loc_d = (^shift_q) ^ rx_s ^ (cfg_odd_q == PARITY_ODD);
          state_d  = ST_STOP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      ST_STOP: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d = '0;
          if (cfg_two_q && !stop2_q) begin
            stop2_d  = 1'b1;
            fe_loc_d = frame_fe;
          end else begin
            // Leave at mid stop bit so the next start edge is caught with
            // half a bit of margin.
            frame_done = 1'b1;
            state_d    = ST_IDLE;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Disabling the receiver discards any partial frame without touching
    // the holding register.
    if (!rx_en) begin
      state_d    = ST_IDLE;
      frame_done = 1'b0;
    end
  end

  // ---------------------------------------------------------------------
  // Holding register and overrun
  // ---------------------------------------------------------------------
  assign handshake = rx_valid_q & rx_ready;
  // A word drained in the same cycle frees the slot for the new frame.
  assign load      = frame_done & (~rx_valid_q | rx_ready);
  assign drop      = frame_done & rx_valid_q & ~rx_ready;

  always_comb begin
    rx_data_d  = rx_data_q;
    rx_valid_d = rx_valid_q;
    perr_d     = perr_q;
    ferr_d     = ferr_q;
    ovr_d      = ovr_q;

    if (load) begin
      rx_data_d  = shift_q;
      perr_d     = pe_loc_q;
      ferr_d     = frame_fe;
      rx_valid_d = 1'b1;
    end else if (handshake) begin
      rx_valid_d = 1'b0;
    end

    // Setting wins over clearing when a drop and a handshake coincide.
    if (drop) begin
      ovr_d = 1'b1;
    end else if (handshake) begin
      ovr_d = 1'b0;
    end
  end

  // ---------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      rx_q       <= 1'b1;
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      idx_q      <= '0;
      shift_q    <= '0;
      stop2_q    <= 1'b0;
      pe_loc_q   <= 1'b0;
      fe_loc_q   <= 1'b0;
      cfg_par_q  <= 1'b0;
      cfg_odd_q  <= 1'b0;
      cfg_two_q  <= 1'b0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      perr_q     <= 1'b0;
      ferr_q     <= 1'b0;
      ovr_q      <= 1'b0;
    end else begin
      rx_q       <= rx_s;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      shift_q    <= shift_d;
      stop2_q    <= stop2_d;
      pe_loc_q   <= pe_loc_d;
      fe_loc_q   <= fe_loc_d;
      cfg_par_q  <= cfg_par_d;
      cfg_odd_q  <= cfg_odd_d;
      cfg_two_q  <= cfg_two_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      perr_q     <= perr_d;
      ferr_q     <= ferr_d;
      ovr_q      <= ovr_d;
    end
  end

  assign rx_data    = rx_data_q;
  assign rx_valid   = rx_valid_q;
  assign parity_err = perr_q;
  assign frame_err  = ferr_q;
  assign overrun    = ovr_q;
  assign busy       = (state_q != ST_IDLE);

endmodule
